// File: rtl/mmio_timer_io.sv
// mmio_timer_io: memory-mapped I/O responder with switch input, LED register,
// a prescaled down-counting timer with sticky expiry flag and interrupt, and
// a scratch register. Reads are combinational; writes land on the rising clock.

module mmio_timer_io #(
    parameter int SW_W       = 3,
    parameter int LED_W      = 16,
    parameter int PRESCALE_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CS,
    input  logic                  WE,
    input  logic [2:0]            ADDR,
    inout  wire  [31:0]           Mem_Bus,
    input  logic [SW_W-1:0]       switches,
    output logic [LED_W-1:0]      led,
    output logic                  irq
);

    // Register word indices
    localparam logic [2:0] ADDR_SW       = 3'd0;
    localparam logic [2:0] ADDR_LED      = 3'd1;
    localparam logic [2:0] ADDR_CTRL     = 3'd2;
    localparam logic [2:0] ADDR_LOAD     = 3'd3;
    localparam logic [2:0] ADDR_COUNT    = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;
    localparam logic [2:0] ADDR_PRESCALE = 3'd6;
    localparam logic [2:0] ADDR_SCRATCH  = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    timer_state_t state_q, state_d;

    logic [SW_W-1:0]       sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]       sw_sync_q, sw_sync_d;
    logic [LED_W-1:0]      led_q, led_d;
    logic                  en_q, en_d;
    logic                  auto_reload_q, auto_reload_d;
    logic                  irq_en_q, irq_en_d;
    logic [31:0]           load_q, load_d;
    logic [31:0]           count_q, count_d;
    logic                  expired_q, expired_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           scratch_q, scratch_d;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        counting;
    logic        tick;
    logic        expire;

    // The bus carries write data from the CPU whenever WE is high
    assign wr_en   = CS & WE;
    assign rd_en   = CS & ~WE;
    assign wr_data = Mem_Bus;

    // Drive the shared bus only while the CPU reads this block
    assign Mem_Bus = rd_en ? rd_data : {32{1'bz}};

    assign led = led_q;
    assign irq = expired_q & irq_en_q;

    // Two-flop synchronizer for the asynchronous board switches
    always_comb begin
        sw_meta_d = switches;
        sw_sync_d = sw_meta_q;
    end

    // Timer FSM next state: RUN follows the enable bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_q)  state_d = RUN;
            RUN:     if (!en_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timer FSM outputs: prescaler advance and tick generation
    always_comb begin
        counting = (state_q == RUN) && en_q;
        tick     = counting && (pcnt_q == prescale_q);
        expire   = tick && (count_q == 32'd0);
        pcnt_d   = '0;
        if (counting && !tick) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // Register file updates; a bus write always wins over timer activity,
    // except that a timer expiry wins over a STATUS clear
    always_comb begin
        led_d         = led_q;
        en_d          = en_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        load_d        = load_q;
        count_d       = count_q;
        expired_d     = expired_q;
        prescale_d    = prescale_q;
        scratch_d     = scratch_q;

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (auto_reload_q) begin
                count_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (wr_en) begin
            case (ADDR)
                ADDR_LED:      led_d = wr_data[LED_W-1:0];
                ADDR_CTRL: begin
                    en_d          = wr_data[0];
                    auto_reload_d = wr_data[1];
                    irq_en_d      = wr_data[2];
                end
                ADDR_LOAD:     load_d = wr_data;
                ADDR_COUNT:    count_d = wr_data;
                ADDR_STATUS:   if (wr_data[0]) expired_d = 1'b0;
                ADDR_PRESCALE: prescale_d = wr_data[PRESCALE_W-1:0];
                ADDR_SCRATCH:  scratch_d = wr_data;
                default:       ;
            endcase
        end

        if (expire) begin
            expired_d = 1'b1;
        end
    end

    // Read mux: unused upper bits of narrow registers read as zero
    always_comb begin
        rd_data = '0;
        case (ADDR)
            ADDR_SW:       rd_data[SW_W-1:0] = sw_sync_q;
            ADDR_LED:      rd_data[LED_W-1:0] = led_q;
            ADDR_CTRL:     rd_data[2:0] = {irq_en_q, auto_reload_q, en_q};
            ADDR_LOAD:     rd_data = load_q;
            ADDR_COUNT:    rd_data = count_q;
            ADDR_STATUS:   rd_data[0] = expired_q;
            ADDR_PRESCALE: rd_data[PRESCALE_W-1:0] = prescale_q;
            ADDR_SCRATCH:  rd_data = scratch_q;
            default:       rd_data = '0;
        endcase
    end

    // State register; reset clears everything immediately, even mid-count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            sw_meta_q     <= '0;
            sw_sync_q     <= '0;
            led_q         <= '0;
            en_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            load_q        <= '0;
            count_q       <= '0;
            expired_q     <= 1'b0;
            prescale_q    <= '0;
            pcnt_q        <= '0;
            scratch_q     <= '0;
        end else begin
            state_q       <= state_d;
            sw_meta_q     <= sw_meta_d;
            sw_sync_q     <= sw_sync_d;
            led_q         <= led_d;
            en_q          <= en_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            load_q        <= load_d;
            count_q       <= count_d;
            expired_q     <= expired_d;
            prescale_q    <= prescale_d;
            pcnt_q        <= pcnt_d;
            scratch_q     <= scratch_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer_io.sv
// tb_mmio_timer_io: scoreboard bench for mmio_timer_io. Expected values are
// pushed when a read or output check is issued and popped when the DUT value
// is sampled. All stimulus is applied one time unit after a rising edge.

module tb_mmio_timer_io;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        we;
    logic [2:0]  addr;
    logic        bus_oe;
    logic [31:0] bus_val;
    wire  [31:0] mem_bus;
    logic [2:0]  switches;
    logic [15:0] led;
    logic        irq;

    int errors;
    int checks;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    localparam logic [2:0] A_SW       = 3'd0;
    localparam logic [2:0] A_LED      = 3'd1;
    localparam logic [2:0] A_CTRL     = 3'd2;
    localparam logic [2:0] A_LOAD     = 3'd3;
    localparam logic [2:0] A_COUNT    = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;
    localparam logic [2:0] A_PRESCALE = 3'd6;
    localparam logic [2:0] A_SCRATCH  = 3'd7;

    assign mem_bus = bus_oe ? bus_val : {32{1'bz}};

    mmio_timer_io #(
        .SW_W(3),
        .LED_W(16),
        .PRESCALE_W(16)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .CS(cs),
        .WE(we),
        .ADDR(addr),
        .Mem_Bus(mem_bus),
        .switches(switches),
        .led(led),
        .irq(irq)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] expected);
        exp_q.push_back(expected);
        tag_q.push_back(tag);
    endtask

    task automatic popCompare(input logic [31:0] observed);
        if (exp_q.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'd1, 32'd0);
        end else begin
            checkOutput(tag_q.pop_front(), observed, exp_q.pop_front());
        end
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [2:0] a,
                                 input logic drv, input logic [31:0] d);
        cs      = c;
        we      = w;
        addr    = a;
        bus_oe  = drv;
        bus_val = d;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, a, 1'b1, d);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
    endtask

    task automatic busRead(input logic [2:0] a, input logic [31:0] expected, input string tag);
        applyStimulus(1'b1, 1'b0, a, 1'b0, 32'd0);
        pushExpect(tag, expected);
        #1;
        popCompare(mem_bus);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
    endtask

    task automatic checkNow(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        pushExpect(tag, expected);
        popCompare(observed);
    endtask

    // Main stimulus sequence
    initial begin
        logic [31:0] os_count [5];
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        switches = 3'b000;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
        os_count = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

        // Reset state
        #12;
        checkNow("rstLed", {16'h0, led}, 32'd0);
        checkNow("rstIrq", {31'h0, irq}, 32'd0);
        rst = 1'b0;
        idleCycle();
        busRead(A_COUNT, 32'd0, "initCount");
        busRead(A_CTRL, 32'd0, "initCtrl");

        // LED and scratch registers
        busWrite(A_LED, 32'h0001_A5A5);
        checkNow("ledPort", {16'h0, led}, 32'h0000_A5A5);
        busRead(A_LED, 32'h0000_A5A5, "ledRead");
        busWrite(A_SCRATCH, 32'hDEAD_BEEF);
        busRead(A_SCRATCH, 32'hDEAD_BEEF, "scratchRead");

        // Switch synchronizer: two edges before the value is visible
        switches = 3'b101;
        idleCycle();
        busRead(A_SW, 32'd0, "swAfter1");
        idleCycle();
        busRead(A_SW, 32'd5, "swAfter2");
        busWrite(A_SW, 32'hFFFF_FFFF);
        busRead(A_SW, 32'd5, "swWriteIgnored");

        // Bus hygiene: the bench drives zero while the block must stay off
        idleCycle();
        applyStimulus(1'b1, 1'b1, A_SCRATCH, 1'b1, 32'd0);
        #1;
        checkNow("hygWriteNoDrive", mem_bus, 32'd0);
        applyStimulus(1'b0, 1'b0, A_SCRATCH, 1'b1, 32'd0);
        #1;
        checkNow("hygCsLowNoDrive", mem_bus, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
        busRead(A_SCRATCH, 32'hDEAD_BEEF, "scratchKept");

        // One-shot: COUNT=3 expires on the fourth tick after RUN is entered
        busWrite(A_PRESCALE, 32'd0);
        busWrite(A_COUNT, 32'd3);
        busWrite(A_CTRL, 32'h5);
        for (int k = 1; k <= 5; k++) begin
            idleCycle();
            busRead(A_COUNT, os_count[k-1], $sformatf("osCount%0d", k));
            checkNow($sformatf("osIrq%0d", k), {31'h0, irq}, (k == 5) ? 32'd1 : 32'd0);
        end
        busRead(A_STATUS, 32'd1, "osExpired");
        busRead(A_CTRL, 32'h4, "osEnCleared");
        idleCycle();
        idleCycle();
        busRead(A_COUNT, 32'd0, "osCountHold");
        busWrite(A_STATUS, 32'd1);
        checkNow("osIrqCleared", {31'h0, irq}, 32'd0);
        busRead(A_STATUS, 32'd0, "osStatusCleared");

        // Auto-reload with PRESCALE=2: tick every 3 cycles, expiry every 6
        busWrite(A_PRESCALE, 32'd2);
        busWrite(A_LOAD, 32'd1);
        busWrite(A_COUNT, 32'd1);
        busWrite(A_CTRL, 32'h3);
        for (int k = 1; k <= 13; k++) begin
            if (k == 8) busWrite(A_STATUS, 32'd1);
            else        idleCycle();
            busRead(A_COUNT, ((((k - 1) / 3) % 2) == 0) ? 32'd1 : 32'd0, $sformatf("arCount%0d", k));
            busRead(A_STATUS, (k == 7 || k == 13) ? 32'd1 : 32'd0, $sformatf("arExpired%0d", k));
            checkNow($sformatf("arIrq%0d", k), {31'h0, irq}, 32'd0);
        end

        // Collisions with PRESCALE=0, LOAD=0, COUNT=0: every tick expires
        busWrite(A_CTRL, 32'd0);
        busWrite(A_STATUS, 32'd1);
        busWrite(A_PRESCALE, 32'd0);
        busWrite(A_LOAD, 32'd0);
        busWrite(A_COUNT, 32'd0);
        busWrite(A_CTRL, 32'h3);
        idleCycle();
        busRead(A_STATUS, 32'd0, "colBefore");
        busWrite(A_STATUS, 32'd1);
        busRead(A_STATUS, 32'd1, "colStatusSetWins");
        busWrite(A_COUNT, 32'h10);
        busRead(A_COUNT, 32'h10, "colCountWriteWins");
        idleCycle();
        busRead(A_COUNT, 32'hF, "colCountNextTick");
        busWrite(A_CTRL, 32'd0);

        // Asynchronous reset in the middle of a run
        busWrite(A_PRESCALE, 32'd0);
        busWrite(A_COUNT, 32'd5);
        busWrite(A_LED, 32'h1234);
        busWrite(A_CTRL, 32'h5);
        idleCycle();
        idleCycle();
        busRead(A_COUNT, 32'd4, "preRstCount");
        checkNow("preRstIrq", {31'h0, irq}, 32'd1);
        rst = 1'b1;
        #1;
        checkNow("rstMidLed", {16'h0, led}, 32'd0);
        checkNow("rstMidIrq", {31'h0, irq}, 32'd0);
        busRead(A_COUNT, 32'd0, "rstMidCount");
        busRead(A_CTRL, 32'd0, "rstMidCtrl");
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 32'hA5A5_A5A5);
        #1;
        checkNow("rstMidBusFree", mem_bus, 32'hA5A5_A5A5);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
        rst = 1'b0;
        idleCycle();
        idleCycle();
        busRead(A_COUNT, 32'd0, "postRstCount");
        busRead(A_STATUS, 32'd0, "postRstStatus");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
